// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared constants and types for the SPI mode-0 slave.
//   SPI_WORD_W  - default serial word length in bits
//   SPI_CNT_W   - bit-counter width for the default word length
//   spi_state_e - frame state (IDLE while cs high, ACTIVE while cs low)
package spi_slave_pkg;

    localparam int unsigned SPI_WORD_W = 16;
    localparam int unsigned SPI_CNT_W  = $clog2(SPI_WORD_W);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchroniser for an asynchronous pin, with
// registered rise/fall pulses detected on the synchronised level.
//   clk, rst  - system clock, synchronous active-high reset
//   d_i       - asynchronous input pin
//   level_o   - synchronised level (last synchroniser stage)
//   rise_o    - one-cycle pulse, SYNC_STAGES+1 cycles after a pin rise
//   fall_o    - one-cycle pulse, SYNC_STAGES+1 cycles after a pin fall
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Pulses are suppressed until the pipeline and the delayed copy hold only
    // real samples, so a pin that differs from RST_VAL at reset release does
    // not produce a phantom edge.
    localparam int unsigned PRIME   = STAGES + 1;
    localparam int unsigned PRIME_W = $clog2(PRIME + 1);

    logic [STAGES-1:0]  sync_q;
    logic               prev_q;
    logic               rise_q;
    logic               fall_q;
    logic [PRIME_W-1:0] prime_q;
    logic               primed;
    logic               level;

    assign level  = sync_q[STAGES-1];
    assign primed = (prime_q == PRIME_W'(PRIME));

    // Synchroniser chain, delayed copy and edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d_i);
            prev_q <= level;
            rise_q <= primed & level & ~prev_q;
            fall_q <= primed & ~level & prev_q;
            if (!primed) begin
                prime_q <= prime_q + PRIME_W'(1);
            end
        end
    end

    assign level_o = level;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) slave, MSB first, oversampled by clk.
//   clk, rst - system clock (>= 8x sclk), synchronous active-high reset
//   sclk     - SPI clock from master (async, idles low)
//   cs       - chip select, active low (async)
//   mosi     - master-out data (async)
//   miso     - slave-out data, registered, 0 while idle
//   rx_data  - last complete received word, registered
//   tx_data  - word to send, sampled at frame start and word boundaries
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = SPI_WORD_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    input  logic [DATA_WIDTH-1:0] tx_data
);

    localparam int unsigned   CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_rise, cs_fall, cs_level_unused;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_state_e            state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
    logic                  miso_q,     miso_d;
    logic [DATA_WIDTH-1:0] rx_next;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .d_i     (sclk),
        .level_o (sclk_level_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .d_i     (cs),
        .level_o (cs_level_unused),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // Same depth as sclk so the level seen at a detected rise matches that edge.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .d_i     (mosi),
        .level_o (mosi_sync),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    assign rx_next = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            miso_q     <= miso_d;
        end
    end

    // Next-state and datapath update; a cs rise takes priority over sclk edges.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        miso_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    tx_shift_d = tx_data;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    // Partial word is dropped; rx_data keeps the last full word.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (cnt_q == CNT_LAST) begin
                        rx_data_d = rx_next;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // Counter at 0 after a fall means a word just completed.
                    if (cnt_q == '0) begin
                        tx_shift_d = tx_data;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        miso_d = (state_d == ACTIVE) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
    end

    assign miso    = miso_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed plus randomized mode-0 frames against a word-level
// reference: the expected rx_data is the last complete word the bench sent,
// and the expected miso bit at each sclk rise is the matching bit of the
// tx word that was current at the word boundary.
module tb_spi_slave;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        miso;
    logic [15:0] rx_data;
    logic [15:0] tx_data;

    int          n_chk;
    int          n_pass;
    int          n_fail;
    logic [15:0] model_rx;

    spi_slave #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .rx_data (rx_data),
        .tx_data (tx_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Half an sclk period (5 clk cycles); inputs change on falling clk edges.
    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    // One mode-0 bit: drive mosi while sclk low, check miso as the master would
    // sample it at the rise, then complete the sclk period.
    task automatic spi_bit(input logic b, input logic exp_miso, input string tag);
        mosi = b;
        half();
        check({tag, " miso"}, {15'b0, miso}, {15'b0, exp_miso});
        sclk = 1'b1;
        half();
        sclk = 1'b0;
    endtask

    // A cs frame of nwords words; tx_data switches to tx1 mid-way through the
    // first word, which must only take effect at the next word boundary.
    task automatic run_frame(input int nwords, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] tx0, input logic [15:0] tx1, input string tag);
        logic [15:0] w;
        logic [15:0] t;
        tx_data = tx0;
        cs      = 1'b0;
        half();
        for (int k = 0; k < nwords; k++) begin
            w = (k == 0) ? w0 : w1;
            t = (k == 0) ? tx0 : tx1;
            for (int i = 15; i >= 0; i--) begin
                if (k == 0 && i == 7) tx_data = tx1;
                spi_bit(w[i], t[i], tag);
            end
            model_rx = w;
            check({tag, " rx"}, rx_data, model_rx);
        end
        half();
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check({tag, " idle miso"}, {15'b0, miso}, 16'h0000);
        check({tag, " idle rx"}, rx_data, model_rx);
    endtask

    initial begin
        logic [15:0] t;
        n_chk    = 0;
        n_pass   = 0;
        n_fail   = 0;
        model_rx = 16'h0000;
        rst      = 1'b1;
        cs       = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        tx_data  = 16'hA5A5;

        // Reset
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset rx", rx_data, 16'h0000);
        check("reset miso", {15'b0, miso}, 16'h0000);

        // Full word
        run_frame(1, 16'h55AA, 16'h0000, 16'hA5A5, 16'hA5A5, "full");

        // Aborted frame: three bits then cs high
        t       = 16'h1234;
        tx_data = t;
        cs      = 1'b0;
        half();
        for (int i = 15; i >= 13; i--) spi_bit(1'b0, t[i], "abort");
        half();
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check("abort rx kept", rx_data, model_rx);

        run_frame(1, 16'($urandom), 16'h0000, 16'h1234, 16'h1234, "after abort");

        // Reset mid-frame; cs stays low afterwards and the rest is ignored
        t       = 16'hC3C3;
        tx_data = t;
        cs      = 1'b0;
        half();
        spi_bit(1'b1, t[15], "pre reset");
        spi_bit(1'b0, t[14], "pre reset");
        rst = 1'b1;
        repeat (10) @(negedge clk);
        rst      = 1'b0;
        model_rx = 16'h0000;
        @(negedge clk);
        check("midreset rx", rx_data, 16'h0000);
        check("midreset miso", {15'b0, miso}, 16'h0000);
        for (int i = 0; i < 16; i++) spi_bit(1'($urandom), 1'b0, "stale frame");
        check("stale frame rx", rx_data, model_rx);
        half();
        cs = 1'b1;
        repeat (10) @(negedge clk);

        // Post-reset frame
        run_frame(1, 16'hF0AA, 16'h0000, 16'hFF00, 16'hFF00, "post reset");

        // Back-to-back words in one frame
        run_frame(2, 16'h1234, 16'hBEEF, 16'($urandom), 16'($urandom), "b2b");

        // Randomized frames
        for (int r = 0; r < 6; r++) begin
            run_frame(int'($urandom_range(1, 2)), 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
